// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo I2S / left-justified serial transmitter.
// A one-deep holding register accepts sample pairs; each frame start loads the
// held pair (or repeats the previous one on underrun) into a frame shift
// register that is clocked out on falling edges of the generated bit clock.
// Optional feature: define AUDIO_I2S_MIX_EN to build the centred L/R mix.
module audio_i2s_tx #(
  parameter int SAMPLE_W = 15,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                exchan,
  input  logic                mix,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  output logic                aud_bclk,
  output logic                aud_lrclk,
  output logic                aud_dat,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = $clog2(BCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);

  // Bit clock generation and frame position
  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             lrclk_q, lrclk_d;
  logic             dat_q, dat_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  // Sample storage
  logic [SAMPLE_W-1:0] prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                full_q, full_d;
  logic                ready_q, ready_d;
  logic                underrun_q, underrun_d;

  // Event strobes
  logic div_wrap, fall, frame_start, fs_next, accept;
  logic [BIT_W-1:0] bit_nxt;

  // Pair presented at the next load, after exchan/mix
  logic [SAMPLE_W-1:0] pair_a, pair_b, mix_l, mix_r, load_l, load_r;
  logic [FRAME_W-1:0]  new_frame;

  // Place a sample MSB-first at the top of its slot, zero-filling the tail.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [SAMPLE_W-1:0] s);
    to_slot = SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  // Decode divider wrap, bclk falling edge and frame boundaries
  always_comb begin
    div_wrap    = (div_q == DIV_W'(BCLK_DIV - 1));
    fall        = div_wrap && bclk_q;
    frame_start = fall && (bit_q == BIT_W'(FRAME_W - 1));
    // Cycle just before a frame start: drop in_ready so nothing is accepted on it.
    fs_next     = bclk_q && (bit_q == BIT_W'(FRAME_W - 1)) &&
                  (div_q == DIV_W'(BCLK_DIV - 2));
    accept      = in_valid && ready_q;
    bit_nxt     = (bit_q == BIT_W'(FRAME_W - 1)) ? '0 : bit_q + BIT_W'(1);
  end

  // Channel swap and optional centred mix of the held pair
  always_comb begin
    pair_a = exchan ? hold_r_q : hold_l_q;
    pair_b = exchan ? hold_l_q : hold_r_q;
    mix_l  = pair_a;
    mix_r  = pair_b;
`ifdef AUDIO_I2S_MIX_EN
    if (mix) begin
      logic signed [SAMPLE_W+1:0] ext_a, ext_b, sum_l, sum_r;
      ext_a = {{2{pair_a[SAMPLE_W-1]}}, pair_a};
      ext_b = {{2{pair_b[SAMPLE_W-1]}}, pair_b};
      sum_l = (ext_a <<< 1) + ext_a + ext_b;
      sum_r = (ext_b <<< 1) + ext_b + ext_a;
      // Dropping the two LSBs is the arithmetic >>> 2; the range cannot overflow.
      mix_l = sum_l[SAMPLE_W+1:2];
      mix_r = sum_r[SAMPLE_W+1:2];
    end
`endif
    load_l    = full_q ? mix_l : prev_l_q;
    load_r    = full_q ? mix_r : prev_r_q;
    new_frame = {to_slot(load_l), to_slot(load_r)};
  end

`ifndef AUDIO_I2S_MIX_EN
  logic unused_mix;
  assign unused_mix = mix;
`endif

  // Next-state logic for the serializer, holding register and handshake
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
    bclk_d     = div_wrap ? ~bclk_q : bclk_q;
    bit_d      = bit_q;
    lrclk_d    = lrclk_q;
    dat_d      = dat_q;
    shift_d    = shift_q;
    prev_l_d   = prev_l_q;
    prev_r_d   = prev_r_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    full_d     = full_q;
    underrun_d = frame_start && !full_q;

    if (fall) begin
      bit_d   = bit_nxt;
      lrclk_d = (bit_nxt >= BIT_W'(SLOT_W));
      if (frame_start) begin
        prev_l_d = load_l;
        prev_r_d = load_r;
        if (MODE == 1) begin
          dat_d   = new_frame[FRAME_W-1];
          shift_d = new_frame << 1;
        end else begin
          // The old right-slot LSB still occupies the first bit time.
          dat_d   = shift_q[FRAME_W-1];
          shift_d = new_frame;
        end
      end else begin
        dat_d   = shift_q[FRAME_W-1];
        shift_d = shift_q << 1;
      end
    end

    if (frame_start) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d   = 1'b1;
      hold_l_d = in_l;
      hold_r_d = in_r;
    end

    ready_d = !full_d && !fs_next;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      bit_q      <= '0;
      lrclk_q    <= 1'b0;
      dat_q      <= 1'b0;
      shift_q    <= '0;
      prev_l_q   <= '0;
      prev_r_q   <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bit_q      <= bit_d;
      lrclk_q    <= lrclk_d;
      dat_q      <= dat_d;
      shift_q    <= shift_d;
      prev_l_q   <= prev_l_d;
      prev_r_q   <= prev_r_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  // Holding data registers, qualified by full_q
  always_ff @(posedge clk) begin
    // NOTE: data-only storage needs no reset; full_q marks whether it is meaningful.
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign in_ready  = ready_q;
  assign aud_bclk  = bclk_q;
  assign aud_lrclk = lrclk_q;
  assign aud_dat   = dat_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: instance 0 uses default parameters (MODE 0),
// instance 1 uses MODE 1 with 16-bit samples. Serial data is sampled on the
// rising edge of aud_bclk as a codec would.
module tb_audio_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        exchan0, mix0, v0, rdy0, bclk0, lr0, dat0, uf0;
  logic [14:0] l0, r0;
  logic        exchan1, mix1, v1, rdy1, bclk1, lr1, dat1, uf1;
  logic [15:0] l1, r1;

  audio_i2s_tx u_dut0 (
    .clk(clk), .rst_n(rst_n), .exchan(exchan0), .mix(mix0),
    .in_valid(v0), .in_ready(rdy0), .in_l(l0), .in_r(r0),
    .aud_bclk(bclk0), .aud_lrclk(lr0), .aud_dat(dat0), .underrun(uf0)
  );

  audio_i2s_tx #(.SAMPLE_W(16), .SLOT_W(16), .BCLK_DIV(4), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .exchan(exchan1), .mix(mix1),
    .in_valid(v1), .in_ready(rdy1), .in_l(l1), .in_r(r1),
    .aud_bclk(bclk1), .aud_lrclk(lr1), .aud_dat(dat1), .underrun(uf1)
  );

  int   sel = 0;
  logic mon_bclk, mon_lr, mon_dat;
  always_comb begin
    mon_bclk = (sel == 0) ? bclk0 : bclk1;
    mon_lr   = (sel == 0) ? lr0   : lr1;
    mon_dat  = (sel == 0) ? dat0  : dat1;
  end

  int total = 0;
  int bad   = 0;

  // Underrun pulse counter and width watch for instance 0
  int   uf_cnt0 = 0;
  int   uf_wide = 0;
  logic uf0_prev = 1'b0;
  always @(negedge clk) begin
    if (uf0 === 1'b1 && uf0_prev === 1'b1) uf_wide++;
    if (uf0 === 1'b1) uf_cnt0++;
    uf0_prev = uf0;
  end

  task automatic get_bit(output logic d, output logic lr);
    int n = 0;
    while (mon_bclk !== 1'b0 && n < 64) begin @(negedge clk); n++; end
    while (mon_bclk !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL bclk_timeout: no bclk rise within %0d clks (sel=%0d)", n, sel);
    end
    d  = mon_dat;
    lr = mon_lr;
  endtask

  // Capture one frame starting at the first bit time after lrclk falls.
  task automatic capture(output logic [15:0] left, output logic [15:0] right,
                         output logic [32:0] s, output logic [32:0] lrs,
                         output int uf_delta);
    logic d, lr, prev_lr;
    int   start_cnt;
    int   n;
    start_cnt = uf_cnt0;
    n = 0;
    prev_lr = 1'b0;
    get_bit(d, lr);
    while (!(prev_lr === 1'b1 && lr === 1'b0) && n < 80) begin
      prev_lr = lr;
      get_bit(d, lr);
      n++;
    end
    if (n >= 80) begin
      total++; bad++;
      $display("FAIL frame_sync: no lrclk fall within %0d bits", n);
    end
    uf_delta = uf_cnt0 - start_cnt;
    s[0] = d; lrs[0] = lr;
    for (int i = 1; i < 33; i++) begin
      get_bit(d, lr);
      s[i] = d; lrs[i] = lr;
    end
    for (int i = 0; i < 16; i++) begin
      if (sel == 0) begin
        left[15-i]  = s[1+i];
        right[15-i] = s[17+i];
      end else begin
        left[15-i]  = s[i];
        right[15-i] = s[16+i];
      end
    end
  endtask

  task automatic send(input int which, input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    while (((which == 0) ? rdy0 : rdy1) !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL ready_timeout: in_ready stayed low (dut %0d)", which);
    end
    if (which == 0) begin v0 = 1'b1; l0 = l[14:0]; r0 = r[14:0]; end
    else            begin v1 = 1'b1; l1 = l;       r1 = r;       end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  logic [15:0] left, right;
  logic [32:0] s, lrs;
  int          ufd;

  task automatic test_reset;
    int n;
    logic seen_high;
    sel = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({bclk0, lr0, dat0, uf0} !== 4'b0000) begin bad++; $display("FAIL reset_outs0: got %b expected 0000", {bclk0, lr0, dat0, uf0}); end
    total++; if ({bclk1, lr1, dat1, uf1} !== 4'b0000) begin bad++; $display("FAIL reset_outs1: got %b expected 0000", {bclk1, lr1, dat1, uf1}); end
    total++; if ({rdy0, rdy1} !== 2'b11) begin bad++; $display("FAIL reset_ready: got %b expected 11", {rdy0, rdy1}); end
    rst_n = 1'b1;
    n = 0;
    seen_high = 1'b0;
    while (n < 40) begin
      @(posedge clk); n++;
      #1;
      if (bclk0 === 1'b1) seen_high = 1'b1;
      else if (seen_high) break;
    end
    total++; if (n !== 8) begin bad++; $display("FAIL first_fall: got %0d clks expected 8", n); end
    capture(left, right, s, lrs, ufd);
    total++; if ({left, right} !== 32'h0) begin bad++; $display("FAIL reset_frame: got %h expected 00000000", {left, right}); end
    total++; if (ufd !== 1) begin bad++; $display("FAIL reset_underrun: got %0d expected 1", ufd); end
  endtask

  task automatic test_mode0_basic;
    sel = 0;
    send(0, 16'h4001, 16'h2AAA);
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL ready_after_accept: got %b expected 0", rdy0); end
    capture(left, right, s, lrs, ufd);
    total++; if (left !== 16'h8002) begin bad++; $display("FAIL m0_left: got %h expected 8002", left); end
    total++; if (right !== 16'h5554) begin bad++; $display("FAIL m0_right: got %h expected 5554", right); end
    total++; if (s[1:0] !== 2'b10) begin bad++; $display("FAIL m0_msb_delay: got %b expected 10", s[1:0]); end
    total++; if (ufd !== 0) begin bad++; $display("FAIL m0_no_underrun: got %0d expected 0", ufd); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL ready_after_frame: got %b expected 1", rdy0); end
  endtask

  task automatic test_underrun;
    sel = 0;
    for (int f = 0; f < 3; f++) begin
      capture(left, right, s, lrs, ufd);
      total++; if ({left, right} !== 32'h8002_5554) begin bad++; $display("FAIL repeat_frame%0d: got %h expected 80025554", f, {left, right}); end
      total++; if (ufd !== 1) begin bad++; $display("FAIL underrun_frame%0d: got %0d expected 1", f, ufd); end
    end
  endtask

  task automatic test_exchan;
    sel = 0;
    exchan0 = 1'b1;
    send(0, 16'h0100, 16'h0200);
    capture(left, right, s, lrs, ufd);
    exchan0 = 1'b0;
    chk("exchan_left", {16'h0, left}, 32'h0000_0400);
    chk("exchan_right", {16'h0, right}, 32'h0000_0200);
  endtask

  task automatic test_mix;
    logic [15:0] el, er, nl, nr;
`ifdef AUDIO_I2S_MIX_EN
    el = 16'h0258; er = 16'h00C8; nl = 16'hFDA8; nr = 16'hFF38;
`else
    el = 16'h0320; er = 16'h0000; nl = 16'hFCE0; nr = 16'h0000;
`endif
    sel = 0;
    mix0 = 1'b1;
    send(0, 16'd400, 16'd0);
    capture(left, right, s, lrs, ufd);
    chk("mix_pos", {left, right}, {el, er});
    send(0, 16'h7E70, 16'd0);
    capture(left, right, s, lrs, ufd);
    chk("mix_neg", {left, right}, {nl, nr});
    mix0 = 1'b0;
  endtask

  task automatic test_mode1;
    int n;
    logic d, lr;
    sel = 1;
    send(1, 16'h8000, 16'h0001);
    capture(left, right, s, lrs, ufd);
    chk("m1_left", {16'h0, left}, 32'h0000_8000);
    chk("m1_right", {16'h0, right}, 32'h0000_0001);
    chk("m1_msb_at_edge", {30'h0, lrs[0], s[0]}, 32'h1);
    chk("m1_right_edge", {30'h0, lrs[16], lrs[15]}, 32'h2);
    get_bit(d, lr);
    n = 0;
    while (mon_bclk !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    while (mon_bclk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL bclk_period: got %0d expected 8", n); end
    sel = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    sel = 0;
    send(0, 16'h1234, 16'h4321);
    capture(left, right, s, lrs, ufd);
    chk("pre_reset_frame", {left, right}, 32'h2468_8642);
    n = 0;
    while (lr0 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    total++; if (n >= 300) begin bad++; $display("FAIL right_slot_wait: got %0d clks expected <300", n); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({bclk0, lr0, dat0, uf0, rdy0} !== 5'b00001) begin bad++; $display("FAIL mid_reset_outs: got %b expected 00001", {bclk0, lr0, dat0, uf0, rdy0}); end
    rst_n = 1'b1;
    capture(left, right, s, lrs, ufd);
    chk("post_reset_frame", {left, right}, 32'h0);
    total++; if (ufd !== 1) begin bad++; $display("FAIL post_reset_underrun: got %0d expected 1", ufd); end
  endtask

  initial begin
    rst_n = 1'b0;
    exchan0 = 1'b0; mix0 = 1'b0; v0 = 1'b0; l0 = '0; r0 = '0;
    exchan1 = 1'b0; mix1 = 1'b0; v1 = 1'b0; l1 = '0; r1 = '0;
    @(negedge clk);
    test_reset();
    test_mode0_basic();
    test_underrun();
    test_exchan();
    test_mix();
    test_mode1();
    test_reset_mid();
    total++; if (uf_wide !== 0) begin bad++; $display("FAIL underrun_width: got %0d wide pulses expected 0", uf_wide); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
